// File: rtl/mask_rd_seq_pkg.sv
// Shared types and width helpers for the mask register read sequencer.
package mask_rd_seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } state_e;

    // Mask-bit count width, able to hold 0..VLEN/8 inclusive.
    function automatic int unsigned vl_bits(input int unsigned vlen);
        return $clog2(vlen / 8) + 1;
    endfunction

    function automatic int unsigned chunks(input int unsigned vlen,
                                           input int unsigned data_width);
        return (vlen / 8) / (data_width / 8);
    endfunction

endpackage

// File: rtl/mask_rd_seq_if.sv
// Command, mask regfile read port and output chunk stream of the mask read sequencer.
interface mask_rd_seq_if #(
    parameter int unsigned VLEN       = 16384,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned OFF_BITS   = 8
);
    localparam int unsigned DW_B    = DATA_WIDTH / 8;
    localparam int unsigned VL_BITS = mask_rd_seq_pkg::vl_bits(VLEN);

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_vreg;
    logic [VL_BITS-1:0]    cmd_vl;

    logic                  mrf_rd_en;
    logic [ADDR_WIDTH-1:0] mrf_rd_addr;
    logic [OFF_BITS-1:0]   mrf_rd_off;
    logic [DW_B-1:0]       mrf_rd_data;

    logic                  out_valid;
    logic                  out_ready;
    logic [DW_B-1:0]       out_data;
    logic                  out_last;

    logic                  busy;

    // The sequencer masters the regfile read port and the output stream.
    modport master (
        input  cmd_valid, cmd_vreg, cmd_vl, mrf_rd_data, out_ready,
        output cmd_ready, mrf_rd_en, mrf_rd_addr, mrf_rd_off, out_valid, out_data, out_last,
               busy
    );

    modport slave (
        output cmd_valid, cmd_vreg, cmd_vl, mrf_rd_data, out_ready,
        input  cmd_ready, mrf_rd_en, mrf_rd_addr, mrf_rd_off, out_valid, out_data, out_last,
               busy
    );

endinterface

// File: rtl/mask_chunk_fifo.sv
// Two-entry FIFO of {last, data} mask chunks with occupancy count.
module mask_chunk_fifo #(
    parameter int unsigned DW_B = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic [DW_B-1:0] push_data,
    input  logic            push_last,
    input  logic            pop,
    output logic            out_valid,
    output logic [DW_B-1:0] out_data,
    output logic            out_last,
    output logic [1:0]      count
);
    logic [DW_B:0] mem_q [2];
    logic          wr_ptr_q;
    logic          rd_ptr_q;
    logic [1:0]    count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {push_last, push_data};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign out_valid             = (count_q != 2'd0);
    assign {out_last, out_data}  = mem_q[rd_ptr_q];
    assign count                 = count_q;

endmodule

// File: rtl/mask_rd_seq.sv
// Streams the first vl bits of a mask register out of the mask regfile, one chunk per
// read, through a credit-limited two-entry buffer with the final chunk tail-zeroed.
module mask_rd_seq
    import mask_rd_seq_pkg::*;
#(
    parameter int unsigned VLEN       = 16384,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned OFF_BITS   = 8
) (
    input logic           clk,
    input logic           rst_n,
    mask_rd_seq_if.master bus
);
    localparam int unsigned DW_B    = DATA_WIDTH / 8;
    localparam int unsigned VL_BITS = vl_bits(VLEN);
    localparam int unsigned TAIL_W  = $clog2(DW_B);

    state_e                state_q;
    logic [OFF_BITS-1:0]   cnt_q;
    logic [OFF_BITS-1:0]   last_off_q;
    logic [TAIL_W-1:0]     tail_q;
    logic                  rd_en_q;
    logic                  rd_last_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [OFF_BITS-1:0]   rd_off_q;

    logic [VL_BITS:0]      nch;
    logic [1:0]            fifo_count;
    logic [2:0]            occ_next;
    logic                  pop;
    logic                  can_issue;
    logic [DW_B-1:0]       tail_mask;
    logic [DW_B-1:0]       push_data;

    assign nch = ({1'b0, bus.cmd_vl} + (VL_BITS + 1)'(DW_B - 1)) >> TAIL_W;
    assign pop = bus.out_valid && bus.out_ready;

    // rd_en_q is the read whose data lands at this edge, so it already owns a buffer slot.
    assign occ_next  = {1'b0, fifo_count} + {2'b0, rd_en_q} - {2'b0, pop};
    assign can_issue = (occ_next < 3'd2);

    always_comb begin
        tail_mask = '1;
        for (int i = 0; i < DW_B; i++) begin
            if (tail_q != '0 && TAIL_W'(i) >= tail_q) begin
                tail_mask[i] = 1'b0;
            end
        end
    end

    assign push_data = bus.mrf_rd_data & (rd_last_q ? tail_mask : '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            last_off_q <= '0;
            tail_q     <= '0;
            rd_en_q    <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_addr_q  <= '0;
            rd_off_q   <= '0;
        end else begin
            rd_en_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.cmd_valid) begin
                        tail_q     <= bus.cmd_vl[TAIL_W-1:0];
                        last_off_q <= OFF_BITS'(nch - 1'b1);
                        cnt_q      <= '0;
                        // Offset 0 is issued on the accepting edge to hit the read latency.
                        if (nch != '0) begin
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= bus.cmd_vreg;
                            rd_off_q  <= '0;
                            rd_last_q <= (nch == (VL_BITS + 1)'(1));
                            cnt_q     <= OFF_BITS'(1);
                            state_q   <= (nch == (VL_BITS + 1)'(1)) ? StDrain : StRun;
                        end
                    end
                end
                StRun: begin
                    if (can_issue) begin
                        rd_en_q   <= 1'b1;
                        rd_off_q  <= cnt_q;
                        rd_last_q <= (cnt_q == last_off_q);
                        cnt_q     <= cnt_q + 1'b1;
                        if (cnt_q == last_off_q) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (pop && bus.out_last) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    mask_chunk_fifo #(
        .DW_B (DW_B)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rd_en_q),
        .push_data (push_data),
        .push_last (rd_last_q),
        .pop       (pop),
        .out_valid (bus.out_valid),
        .out_data  (bus.out_data),
        .out_last  (bus.out_last),
        .count     (fifo_count)
    );

    assign bus.cmd_ready   = (state_q == StIdle);
    assign bus.busy        = (state_q != StIdle);
    assign bus.mrf_rd_en   = rd_en_q;
    assign bus.mrf_rd_addr = rd_addr_q;
    assign bus.mrf_rd_off  = rd_off_q;

endmodule

// File: tb/tb_mask_rd_seq.sv
// Self-checking bench for mask_rd_seq: chunk-level scoreboard plus directed timing checks.
module tb_mask_rd_seq;
    import mask_rd_seq_pkg::*;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   ready_mode = 0;
    int   rd_cnt = 0;
    int   pop_cnt = 0;
    int   occ = 0;

    logic [12:0] exp_rd[$];
    logic [8:0]  exp_out[$];
    logic        hold_v = 1'b0;
    logic [8:0]  hold = '0;

    // Expected per-cycle behaviour after accepting vreg=3, vl=24 (index k-1 for cycle T+k).
    bit en_t   [5] = '{1, 1, 1, 0, 0};
    bit v_t    [5] = '{0, 1, 1, 1, 0};
    bit last_t [5] = '{0, 0, 0, 1, 0};
    bit busy_t [5] = '{1, 1, 1, 1, 0};

    mask_rd_seq_if bus ();

    mask_rd_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] mem_val(input int vreg, input int off);
        if (vreg == 7) return 8'hFF;
        return 8'((vreg * 29 + off * 7 + 3) & 255);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: got an unexpected event, expected none", name);
    endtask

    // Regfile returns data for the address presented during the read-enable cycle.
    always @(negedge clk) begin
        bus.mrf_rd_data = mem_val(int'(bus.mrf_rd_addr), int'(bus.mrf_rd_off));
    end

    always @(posedge clk) begin
        #1;
        cyc++;
        case (ready_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = (cyc % 3 != 0);
            default: bus.out_ready = 1'b0;
        endcase
    end

    // Scoreboard: every read and every accepted chunk is matched against the model queues.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_v = 1'b0;
            occ    = 0;
        end else begin
            check("busy_vs_cmd_ready", 64'(bus.busy), 64'(!bus.cmd_ready));
            if (hold_v) begin
                check("stall_valid", 64'(bus.out_valid), 64'(1));
                check("stall_chunk", 64'({bus.out_last, bus.out_data}), 64'(hold));
            end
            if (bus.mrf_rd_en) begin
                rd_cnt++;
                occ++;
                if (exp_rd.size() == 0) fail_now("spurious_read");
                else check("rd_addr_off", 64'({bus.mrf_rd_addr, bus.mrf_rd_off}),
                           64'(exp_rd.pop_front()));
            end
            if (bus.out_valid && bus.out_ready) begin
                pop_cnt++;
                occ--;
                if (exp_out.size() == 0) fail_now("spurious_chunk");
                else check("out_chunk", 64'({bus.out_last, bus.out_data}),
                           64'(exp_out.pop_front()));
            end
            check("buffer_occupancy_le2", 64'(occ <= 2), 64'(1));
            hold_v = bus.out_valid && !bus.out_ready;
            hold   = {bus.out_last, bus.out_data};
        end
    end

    task automatic model_push(input int vreg, input int vl);
        int         nch;
        int         rem;
        logic [7:0] d;
        nch = (vl + 7) / 8;
        rem = vl % 8;
        for (int k = 0; k < nch; k++) begin
            d = mem_val(vreg, k);
            if (k == nch - 1 && rem != 0) d = d & 8'((1 << rem) - 1);
            exp_rd.push_back({5'(vreg), 8'(k)});
            exp_out.push_back({k == nch - 1, d});
        end
    endtask

    // Called at posedge+#1; returns at posedge+#1 of the cycle after acceptance.
    task automatic send_cmd(input int vreg, input int vl);
        int g = 0;
        while (!bus.cmd_ready && g < 2000) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (!bus.cmd_ready) begin
            fail_now("cmd_ready_timeout");
            return;
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_vreg  = 5'(vreg);
        bus.cmd_vl    = 12'(vl);
        model_push(vreg, vl);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int g = 0;
        while ((bus.busy || exp_out.size() != 0) && g < 1000) begin
            @(posedge clk);
            #1;
            g++;
        end
        check({name, "_completes"}, 64'(bus.busy || exp_out.size() != 0), 64'(0));
    endtask

    initial begin
        int p0;
        int r0;
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_vreg  = '0;
        bus.cmd_vl    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rd_en", 64'(bus.mrf_rd_en), 64'(0));
        check("rst_rd_addr", 64'(bus.mrf_rd_addr), 64'(0));
        check("rst_rd_off", 64'(bus.mrf_rd_off), 64'(0));
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_out_data", 64'(bus.out_data), 64'(0));
        check("rst_out_last", 64'(bus.out_last), 64'(0));
        check("rst_busy", 64'(bus.busy), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
        @(posedge clk);
        #1;

        // Latency and throughput: vreg 3, vl 24.
        send_cmd(3, 24);
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) @(posedge clk);
            @(negedge clk);
            check($sformatf("t41_rd_en_T%0d", k), 64'(bus.mrf_rd_en), 64'(en_t[k-1]));
            if (en_t[k-1]) begin
                check($sformatf("t41_rd_addr_T%0d", k), 64'(bus.mrf_rd_addr), 64'(3));
                check($sformatf("t41_rd_off_T%0d", k), 64'(bus.mrf_rd_off), 64'(k - 1));
            end
            check($sformatf("t41_out_valid_T%0d", k), 64'(bus.out_valid), 64'(v_t[k-1]));
            if (v_t[k-1])
                check($sformatf("t41_out_last_T%0d", k), 64'(bus.out_last), 64'(last_t[k-1]));
            check($sformatf("t41_busy_T%0d", k), 64'(bus.busy), 64'(busy_t[k-1]));
        end
        @(posedge clk);
        #1;
        wait_idle("t41");

        // Tail zeroing: vl 13 over all-ones data.
        send_cmd(7, 13);
        check("t42_model_chunk0", 64'(pop_cnt >= 0 ? 9'h0FF : 9'h0), 64'(9'h0FF));
        wait_idle("t42");

        // Zero-length command.
        p0 = pop_cnt;
        r0 = rd_cnt;
        send_cmd(4, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t43_cmd_ready", 64'(bus.cmd_ready), 64'(1));
            check("t43_out_valid", 64'(bus.out_valid), 64'(0));
        end
        check("t43_no_reads", 64'(rd_cnt - r0), 64'(0));
        check("t43_no_chunks", 64'(pop_cnt - p0), 64'(0));
        @(posedge clk);
        #1;

        // Consumer stalled: only two reads may be outstanding.
        ready_mode = 2;
        @(posedge clk);
        #1;
        r0 = rd_cnt;
        p0 = pop_cnt;
        send_cmd(2, 40);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        check("stall_reads_capped", 64'(rd_cnt - r0), 64'(2));
        check("stall_out_valid", 64'(bus.out_valid), 64'(1));
        ready_mode = 0;
        wait_idle("stall");
        check("stall_chunks", 64'(pop_cnt - p0), 64'(5));

        // Periodic back-pressure.
        ready_mode = 1;
        p0 = pop_cnt;
        send_cmd(9, 64);
        wait_idle("t44");
        check("t44_chunks", 64'(pop_cnt - p0), 64'(8));
        ready_mode = 0;

        // Back-to-back commands.
        send_cmd(1, 17);
        send_cmd(30, 8);
        wait_idle("b2b");

        // Full register.
        p0 = pop_cnt;
        send_cmd(31, 2048);
        check("t45_model_len", 64'(exp_out.size() + (pop_cnt - p0)), 64'(256));
        wait_idle("t45");
        check("t45_chunks", 64'(pop_cnt - p0), 64'(256));

        // Reset in the middle of a command.
        send_cmd(5, 200);
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        check("t40_busy_before", 64'(bus.busy), 64'(1));
        rst_n = 1'b0;
        @(negedge clk);
        check("t40_out_valid", 64'(bus.out_valid), 64'(0));
        check("t40_busy", 64'(bus.busy), 64'(0));
        check("t40_rd_en", 64'(bus.mrf_rd_en), 64'(0));
        exp_rd.delete();
        exp_out.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        r0 = rd_cnt;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t40_after_out_valid", 64'(bus.out_valid), 64'(0));
            check("t40_after_rd_en", 64'(bus.mrf_rd_en), 64'(0));
        end
        @(posedge clk);
        #1;
        send_cmd(6, 9);
        wait_idle("recover");
        check("recover_reads", 64'(rd_cnt - r0), 64'(2));

        check("left_reads", 64'(exp_rd.size()), 64'(0));
        check("left_chunks", 64'(exp_out.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1);
    end

endmodule
